mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Memory-side stage directly downstream of the icache and dcache.
- Consumes their read/write requests (iREN/iaddr, dREN/dWEN/daddr/dstore) and arbitrates them onto the single RAM port.
- Returns iwait/iload and dwait/dload.
- Data requests have priority, plus a bounded anti-starvation rule for instruction fetch, a per-access timeout, and a sticky error flag.

Parameters:
- MAX_DSTREAK, 4: consecutive dcache completions allowed while iREN is pending before the icache is forced ahead.
- TIMEOUT, 64: cycles a grant may wait for ramstate==ACCESS before it is aborted.
- ERR_WORD, 32'hBAD1BAD1: load value returned on an aborted or errored read.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- iREN  in  1  icache read request.
- iaddr  in  32  icache word address.
- iwait  out  1  low for exactly the cycle the icache access completes.
- iload  out  32  instruction word; valid when iwait=0.
- dREN  in  1  dcache read request.
- dWEN  in  1  dcache write request; never asserted together with dREN.
- daddr  in  32  dcache address.
- dstore  in  32  dcache write data.
- dwait  out  1  low for exactly the cycle the dcache access completes.
- dload  out  32  data word; valid when dwait=0.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  ramstate_t: FREE, BUSY, ACCESS, ERROR.
- err  out  1  sticky; set on ramstate==ERROR or timeout.

Behaviour:
- Reset (RST high, asynchronous):
  - State goes to IDLE; dstreak, tcount and err clear to 0.
  - Outputs while in reset: iwait=dwait=1, iload=dload=0, ramREN=ramWEN=0, ramaddr=ramstore=0.
- FSM states: IDLE, GRANT_I, GRANT_D. The grant is registered, so arbitration costs exactly one cycle (IDLE to GRANT).
- IDLE transitions:
  - To GRANT_D if (dREN|dWEN) and not (iREN and dstreak==MAX_DSTREAK).
  - Else to GRANT_I if iREN.
  - Else stay in IDLE.
  - RAM enables are 0 in IDLE; both waits are 1.
- GRANT_I:
  - ramREN=iREN, ramaddr=iaddr, ramWEN=0.
  - iwait=0 only in the cycle ramstate==ACCESS or ERROR, or on timeout; dwait=1 throughout.
- GRANT_D:
  - ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
  - dwait is symmetric to iwait in GRANT_I; iwait=1 throughout.
- Completion cycle:
  - Granted load = ramload on ACCESS; ERR_WORD on ERROR or timeout.
  - Next state is IDLE. There is no back-to-back grant, so the requester sees its wait drop for one cycle.
- Withdrawal: if the granted requester drops its request mid-grant (e.g. the icache PC changes), enables drop combinationally, FSM returns to IDLE next cycle, and no completion is signalled.
- tcount:
  - Clears on entering a GRANT state; increments each GRANT cycle without ACCESS.
  - At tcount==TIMEOUT-1: complete with ERR_WORD and set err.
  - Width is clog2(TIMEOUT)+1; it never wraps.
- dstreak:
  - Increments on a D completion when iREN=1; saturates at MAX_DSTREAK.
  - Clears on any I completion, or on a D completion while iREN=0.
- Non-granted load outputs hold 0.
- Writes return dload=0.
- err clears only by reset.
- Simultaneous ERROR with requester withdrawal: withdrawal wins, no completion, err still set.

Decomposition:
- cpu_types_pkg holds ramstate_t (2-bit enum FREE/BUSY/ACCESS/ERROR), word_t, and an arb_state_t enum.
- No sub-module; a single FSM plus two counters.

Test Plan:
- Reset mid-grant: assert RST while in GRANT_D with ramWEN=1 -> ramWEN=0, dwait=1 the same cycle; state IDLE after release.
- Single fetch: iREN=1, iaddr=0x40; RAM gives ACCESS on the 3rd grant cycle with ramload=0x8C010004 -> iwait low for exactly one cycle, iload=0x8C010004, ramaddr=0x40 throughout the grant.
- Contention: iREN and dREN rise together, MAX_DSTREAK=4, dREN re-requested continuously -> four D completions, then a GRANT_I; dstreak back to 0.
- Write: dWEN=1, daddr=0x200, dstore=0xDEADBEEF -> ramWEN=1, ramstore=0xDEADBEEF, dwait low one cycle on ACCESS, iwait held 1.
- Timeout: ramstate stuck BUSY with TIMEOUT=64 -> iwait low at grant cycle 64, iload=0xBAD1BAD1, err=1 and stays 1.
- Withdrawal: iREN drops on grant cycle 2 -> ramREN=0 that cycle, iwait never low, state IDLE next cycle.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared types for the cache-to-RAM path: RAM handshake state, data word
// and the memory arbiter FSM encoding.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates icache and dcache requests onto the single RAM port, with data
// priority, bounded instruction starvation, a per-grant timeout and sticky err.
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int    MAX_DSTREAK = 4,
  parameter int    TIMEOUT     = 64,
  parameter word_t ERR_WORD    = 32'hBAD1BAD1
) (
  input  logic      CLK,
  input  logic      RST,
  input  logic      iREN,
  input  word_t     iaddr,
  output logic      iwait,
  output word_t     iload,
  input  logic      dREN,
  input  logic      dWEN,
  input  word_t     daddr,
  input  word_t     dstore,
  output logic      dwait,
  output word_t     dload,
  output logic      ramREN,
  output logic      ramWEN,
  output word_t     ramaddr,
  output word_t     ramstore,
  input  word_t     ramload,
  input  ramstate_t ramstate,
  output logic      err
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam int SW = $clog2(MAX_DSTREAK) + 1;

  arb_state_t      state_q, state_d;
  logic [TW-1:0]   tcount_q, tcount_d;
  logic [SW-1:0]   dstreak_q, dstreak_d;
  logic            err_q, err_d;

  logic hit, fault, expired, dReq;

  assign hit     = (ramstate == ACCESS);
  assign fault   = (ramstate == ERROR);
  assign expired = (tcount_q == TW'(TIMEOUT - 1));
  assign dReq    = dREN | dWEN;
  assign err     = err_q;

  always_comb begin
    state_d   = state_q;
    tcount_d  = tcount_q;
    dstreak_d = dstreak_q;
    err_d     = err_q;
    iwait     = 1'b1;
    dwait     = 1'b1;
    iload     = '0;
    dload     = '0;
    ramREN    = 1'b0;
    ramWEN    = 1'b0;
    ramaddr   = '0;
    ramstore  = '0;

    case (state_q)
      ARB_IDLE: begin
        tcount_d = '0;
        // Data wins unless the icache has already been passed over MAX_DSTREAK times.
        if (dReq && !(iREN && (dstreak_q == SW'(MAX_DSTREAK)))) begin
          state_d = ARB_GRANT_D;
        end else if (iREN) begin
          state_d = ARB_GRANT_I;
        end
      end

      ARB_GRANT_I: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        if (fault) err_d = 1'b1;
        if (!iREN) begin
          state_d = ARB_IDLE;
        end else if (hit || fault || expired) begin
          iwait     = 1'b0;
          iload     = hit ? ramload : ERR_WORD;
          if (!hit) err_d = 1'b1;
          dstreak_d = '0;
          state_d   = ARB_IDLE;
        end else begin
          tcount_d = tcount_q + TW'(1);
        end
      end

      ARB_GRANT_D: begin
        ramREN   = dREN;
        ramWEN   = dWEN;
        ramaddr  = daddr;
        ramstore = dstore;
        if (fault) err_d = 1'b1;
        if (!dReq) begin
          state_d = ARB_IDLE;
        end else if (hit || fault || expired) begin
          dwait = 1'b0;
          if (dREN) dload = hit ? ramload : ERR_WORD;
          if (!hit) err_d = 1'b1;
          if (!iREN) begin
            dstreak_d = '0;
          end else if (dstreak_q != SW'(MAX_DSTREAK)) begin
            dstreak_d = dstreak_q + SW'(1);
          end
          state_d = ARB_IDLE;
        end else begin
          tcount_d = tcount_q + TW'(1);
        end
      end

      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= ARB_IDLE;
      tcount_q  <= '0;
      dstreak_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tcount_q  <= tcount_d;
      dstreak_q <= dstreak_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a small RAM responder, a completion
// scoreboard fed by the stimulus, and a monitor that checks every completion.
module tb_mem_arbiter;
  import cpu_types_pkg::*;

  logic      CLK = 1'b0;
  logic      RST;
  logic      iREN, dREN, dWEN;
  word_t     iaddr, daddr, dstore;
  logic      iwait, dwait, ramREN, ramWEN, err;
  word_t     iload, dload, ramaddr, ramstore, ramload;
  ramstate_t ramstate;

  localparam word_t MAGIC = 32'h8C010044;
  localparam word_t BAD   = 32'hBAD1BAD1;

  typedef struct packed {
    logic  isD;
    word_t data;
  } exp_t;

  exp_t expQ[$];
  exp_t monExp;
  int   compared   = 0;
  int   mismatched = 0;
  int   latency    = 0;
  bit   errMode    = 1'b0;
  int   ramCyc     = 0;
  int   lowAt;

  mem_arbiter #(.MAX_DSTREAK(4), .TIMEOUT(64), .ERR_WORD(32'hBAD1BAD1)) dut (
    .CLK(CLK), .RST(RST),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .err(err)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ir, input word_t ia, input logic dr,
                               input logic dw, input word_t da, input word_t ds);
    iREN = ir; iaddr = ia; dREN = dr; dWEN = dw; daddr = da; dstore = ds;
  endtask

  task automatic clearReq();
    iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expQ.size() != 0 && n < budget) begin
      @(posedge CLK);
      n++;
    end
    if (expQ.size() != 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL drain_timeout: %0d completions outstanding, expected 0", expQ.size());
      expQ.delete();
    end
  endtask

  // RAM model: answers after `latency` enabled cycles, data derived from address.
  always @(posedge CLK) begin
    #2;
    if (ramREN || ramWEN) ramCyc = ramCyc + 1;
    else ramCyc = 0;
    ramload = ramaddr ^ MAGIC;
    if (latency != 0 && ramCyc == latency) ramstate = errMode ? ERROR : ACCESS;
    else if (ramCyc != 0) ramstate = BUSY;
    else ramstate = FREE;
  end

  always @(negedge CLK) begin
    if (!RST && (iwait === 1'b0 || dwait === 1'b0)) begin
      if (expQ.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_completion: iwait=%b dwait=%b, expected none", iwait, dwait);
      end else begin
        monExp = expQ.pop_front();
        checkOutput("completion_kind", {30'b0, ~iwait, ~dwait}, monExp.isD ? 32'd1 : 32'd2);
        checkOutput("completion_data", monExp.isD ? dload : iload, monExp.data);
      end
    end
  end

  initial begin
    RST = 1'b1; ramstate = FREE; ramload = '0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

    #12;
    checkOutput("rst_waits", {30'b0, iwait, dwait}, 32'd3);
    checkOutput("rst_iload", iload, 32'h0);
    checkOutput("rst_dload", dload, 32'h0);
    checkOutput("rst_enables", {30'b0, ramREN, ramWEN}, 32'd0);
    checkOutput("rst_ramaddr", ramaddr, 32'h0);
    checkOutput("rst_ramstore", ramstore, 32'h0);
    checkOutput("rst_err", err, 32'd0);
    @(posedge CLK); #1 RST = 1'b0;

    // Reset asserted in the middle of a write grant.
    @(posedge CLK); #1;
    latency = 0;
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h10, 32'h55);
    @(posedge CLK); #3;
    checkOutput("rstgrant_ramWEN_before", ramWEN, 32'd1);
    RST = 1'b1;
    #1;
    checkOutput("rstgrant_ramWEN", ramWEN, 32'd0);
    checkOutput("rstgrant_dwait", dwait, 32'd1);
    clearReq();
    @(posedge CLK); #1 RST = 1'b0;
    @(posedge CLK); #1;
    checkOutput("rstgrant_state", 32'(dut.state_q), 32'(ARB_IDLE));

    // Single fetch, ACCESS on the third grant cycle.
    latency = 3;
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0);
    expQ.push_back('{1'b0, 32'h8C010004});
    for (int k = 1; k <= 3; k++) begin
      @(posedge CLK); #3;
      checkOutput($sformatf("fetch_ramaddr_c%0d", k), ramaddr, 32'h40);
      checkOutput($sformatf("fetch_ramREN_c%0d", k), ramREN, 32'd1);
    end
    waitDrain(10);
    #1 clearReq();

    // Data write.
    @(posedge CLK); #1;
    latency = 2;
    applyStimulus(1'b0, '0, 1'b0, 1'b1, 32'h200, 32'hDEADBEEF);
    expQ.push_back('{1'b1, 32'h0});
    @(posedge CLK); #3;
    checkOutput("write_ramWEN", ramWEN, 32'd1);
    checkOutput("write_ramREN", ramREN, 32'd0);
    checkOutput("write_ramstore", ramstore, 32'hDEADBEEF);
    checkOutput("write_ramaddr", ramaddr, 32'h200);
    checkOutput("write_iwait", iwait, 32'd1);
    waitDrain(10);
    #1 clearReq();

    // Contention: four data completions, then the fetch is forced through.
    @(posedge CLK); #1;
    latency = 1;
    applyStimulus(1'b1, 32'h44, 1'b1, 1'b0, 32'h300, '0);
    for (int k = 0; k < 4; k++) expQ.push_back('{1'b1, 32'h300 ^ MAGIC});
    expQ.push_back('{1'b0, 32'h44 ^ MAGIC});
    waitDrain(40);
    #1 clearReq();
    checkOutput("contention_dstreak", 32'(dut.dstreak_q), 32'd0);

    // Withdrawal of the fetch on grant cycle 2.
    @(posedge CLK); #1;
    latency = 0;
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0, '0, '0);
    @(posedge CLK); #3;
    checkOutput("withdraw_ramREN_c1", ramREN, 32'd1);
    @(posedge CLK); #1 iREN = 1'b0;
    #2;
    checkOutput("withdraw_ramREN_c2", ramREN, 32'd0);
    checkOutput("withdraw_iwait_c2", iwait, 32'd1);
    @(posedge CLK); #1;
    checkOutput("withdraw_state", 32'(dut.state_q), 32'(ARB_IDLE));
    checkOutput("withdraw_err", err, 32'd0);

    // Timeout: RAM stays BUSY.
    latency = 0;
    applyStimulus(1'b1, 32'h100, 1'b0, 1'b0, '0, '0);
    expQ.push_back('{1'b0, BAD});
    lowAt = 0;
    for (int k = 1; k <= 80; k++) begin
      @(posedge CLK); #3;
      if (iwait == 1'b0) begin
        lowAt = k;
        break;
      end
    end
    checkOutput("timeout_cycle", 32'(lowAt), 32'd64);
    waitDrain(5);
    #1 clearReq();
    checkOutput("timeout_err", err, 32'd1);
    repeat (5) @(posedge CLK);
    #1 checkOutput("timeout_err_sticky", err, 32'd1);

    // RAM ERROR on a data read.
    latency = 2;
    errMode = 1'b1;
    applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h300, '0);
    expQ.push_back('{1'b1, BAD});
    waitDrain(10);
    #1 clearReq();
    errMode = 1'b0;
    checkOutput("error_err", err, 32'd1);

    repeat (3) @(posedge CLK);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
